// File: rtl/sync_up_counter_casc_pkg.sv
// Shared constants, digit type and load clamping helper for the cascaded up counter.
package sync_up_counter_casc_pkg;
  localparam int unsigned DEF_DIGITS  = 4;
  localparam int unsigned DEF_RADIX   = 10;
  localparam int unsigned DEF_DIGIT_W = 4;
  localparam int unsigned DIGIT_MAX   = DEF_RADIX - 1;

  typedef logic [DEF_DIGIT_W-1:0] digit_t;

  // Out-of-range loaded digits saturate at the largest legal digit.
  function automatic int unsigned clamp_digit(input int unsigned value, input int unsigned radix);
    return (value >= radix) ? radix - 1 : value;
  endfunction
endpackage

// File: rtl/sync_up_counter_casc_digit.sv
// One radix-RADIX digit stage: clear > load > step > hold, with an at-max flag for the carry chain.
module up_counter_digit
  import sync_up_counter_casc_pkg::*;
#(
  parameter int unsigned RADIX   = DEF_RADIX,
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max
);
  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = DIGIT_W'(clamp_digit(32'(load_digit), RADIX));
    end else if (step) begin
      digit_d = (digit_q == MAX) ? '0 : digit_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == MAX);
endmodule

// File: rtl/sync_up_counter_casc.sv
// Cascaded synchronous up counter: DIGITS digit stages, AND-chained carries, overflow pulse and sticky flag.
module sync_up_counter_casc
  import sync_up_counter_casc_pkg::*;
#(
  parameter int unsigned DIGITS  = DEF_DIGITS,
  parameter int unsigned RADIX   = DEF_RADIX,
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tc,
  output logic                      carry_out,
  output logic                      ovf_pulse,
  output logic                      ovf_sticky,
  input  logic                      ovf_ack
);
  logic [DIGITS-1:0] at_max;
  logic [DIGITS:0]   lower_max;
  logic              wrap;
  logic              ovf_pulse_q, ovf_pulse_d;
  logic              ovf_sticky_q, ovf_sticky_d;

  assign lower_max[0] = 1'b1;

  // A digit steps only when every lower digit is at max in the same cycle.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign lower_max[gi+1] = lower_max[gi] & at_max[gi];

    up_counter_digit #(
      .RADIX   (RADIX),
      .DIGIT_W (DIGIT_W)
    ) u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (en & lower_max[gi]),
      .clr        (clr),
      .load       (load),
      .load_digit (load_val[gi*DIGIT_W +: DIGIT_W]),
      .digit      (count[gi*DIGIT_W +: DIGIT_W]),
      .at_max     (at_max[gi])
    );
  end

  assign tc        = lower_max[DIGITS];
  assign wrap      = tc & en & ~clr & ~load;
  assign carry_out = wrap;

  always_comb begin
    ovf_pulse_d  = wrap;
    ovf_sticky_d = ovf_sticky_q;
    if (wrap)         ovf_sticky_d = 1'b1;
    else if (ovf_ack) ovf_sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pulse_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_pulse_q  <= ovf_pulse_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_pulse  = ovf_pulse_q;
  assign ovf_sticky = ovf_sticky_q;
endmodule

// File: tb/tb_sync_up_counter_casc.sv
// Scoreboard bench for sync_up_counter_casc with DIGITS=4, RADIX=10 (BCD).
module tb_sync_up_counter_casc;
  localparam int DIGITS  = 4;
  localparam int RADIX   = 10;
  localparam int DIGIT_W = 4;
  localparam int W       = DIGITS * DIGIT_W;
  localparam int MODULUS = RADIX ** DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, load = 1'b0, ovf_ack = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic tc, carry_out, ovf_pulse, ovf_sticky;

  typedef struct {
    logic [W-1:0] cnt;
    logic         pulse;
    logic         sticky;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  int   m_val = 0;
  logic m_pulse = 1'b0;
  logic m_sticky = 1'b0;

  sync_up_counter_casc #(
    .DIGITS  (DIGITS),
    .RADIX   (RADIX),
    .DIGIT_W (DIGIT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .tc         (tc),
    .carry_out  (carry_out),
    .ovf_pulse  (ovf_pulse),
    .ovf_sticky (ovf_sticky),
    .ovf_ack    (ovf_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_packed(input int val);
    logic [W-1:0] p;
    int v;
    p = '0;
    v = val;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % RADIX);
      v = v / RADIX;
    end
    return p;
  endfunction

  function automatic int from_load(input logic [W-1:0] lv);
    int v;
    int d;
    int scale;
    v = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[i*DIGIT_W +: DIGIT_W]);
      if (d > RADIX - 1) d = RADIX - 1;
      v = v + d * scale;
      scale = scale * RADIX;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag, input bit e, input bit c, input bit l, input bit a,
                       input logic [W-1:0] lv);
    exp_t x;
    bit   wrap;
    logic m_tc;
    @(negedge clk);
    en = e; clr = c; load = l; ovf_ack = a; load_val = lv;
    #1;
    m_tc = (m_val == MODULUS - 1);
    chk({tag, "_tc_pre"}, 32'(tc), 32'(m_tc));
    chk({tag, "_carry"}, 32'(carry_out), 32'(m_tc & e & ~c & ~l));
    wrap = 1'b0;
    if (c)      m_val = 0;
    else if (l) m_val = from_load(lv);
    else if (e) begin
      if (m_val == MODULUS - 1) wrap = 1'b1;
      m_val = (m_val + 1) % MODULUS;
    end
    m_pulse = wrap;
    if (wrap)   m_sticky = 1'b1;
    else if (a) m_sticky = 1'b0;
    x.cnt = to_packed(m_val);
    x.pulse = m_pulse;
    x.sticky = m_sticky;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk({tag, "_count"}, 32'(count), 32'(x.cnt));
    chk({tag, "_pulse"}, 32'(ovf_pulse), 32'(x.pulse));
    chk({tag, "_sticky"}, 32'(ovf_sticky), 32'(x.sticky));
    $display("txn %-10s en=%0b clr=%0b load=%0b ack=%0b lv=%h -> count=%h tc=%0b pulse=%0b sticky=%0b",
             tag, e, c, l, a, lv, count, tc, ovf_pulse, ovf_sticky);
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_pulse", 32'(ovf_pulse), 32'h0);
    chk("rst_sticky", 32'(ovf_sticky), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) cycle("count", 1, 0, 0, 0, '0);

    cycle("ld9998", 0, 0, 1, 0, 16'h9998);
    cycle("to9999", 1, 0, 0, 0, '0);
    cycle("wrap", 1, 0, 0, 0, '0);
    cycle("postwrap", 1, 0, 0, 0, '0);
    cycle("ack", 0, 0, 0, 1, '0);

    cycle("ld9999", 0, 0, 1, 0, 16'h9999);
    cycle("wrap_ack", 1, 0, 0, 1, '0);
    cycle("ack2", 0, 0, 0, 1, '0);
    cycle("ack_idle", 0, 0, 0, 1, '0);

    cycle("clr_ld", 0, 1, 1, 0, 16'h1234);
    cycle("ld_clamp", 1, 0, 1, 0, 16'h00AF);
    cycle("clr_max", 0, 0, 1, 0, 16'h9999);
    cycle("clr_at_max", 1, 1, 0, 0, '0);

    cycle("ld0459", 0, 0, 1, 0, 16'h0459);
    for (int i = 0; i < 5; i++) cycle("hold", 0, 0, 0, 0, '0);
    cycle("resume", 1, 0, 0, 0, '0);

    cycle("ld9999b", 0, 0, 1, 0, 16'h9999);
    cycle("wrap2", 1, 0, 0, 0, '0);
    cycle("ld0777", 0, 0, 1, 0, 16'h0777);
    chk("pre_rst_count", 32'(count), 32'h0777);
    chk("pre_rst_sticky", 32'(ovf_sticky), 32'h1);
    en = 1'b0; load = 1'b0; load_val = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'h0);
    chk("async_pulse", 32'(ovf_pulse), 32'h0);
    chk("async_sticky", 32'(ovf_sticky), 32'h0);
    chk("async_tc", 32'(tc), 32'h0);
    m_val = 0; m_pulse = 1'b0; m_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("after_rst", 1, 0, 0, 0, '0);
    cycle("after_rst2", 1, 0, 0, 0, '0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
